// File: rtl/mips32_data_mem.sv
// Word-addressed data memory responder for MIPS32 LW/SW accesses, one request outstanding at a time.
// Latency: response valid WAIT+1 edges after the accept edge; back-to-back spacing is WAIT+3 cycles.
// Backpressure: req_ready low while busy; the response is held stable until resp_ready is seen high.
//
// Ports:
//   clk, reset                        clock and synchronous active-high reset
//   req_valid/req_ready               request handshake (req_we, req_addr, req_wdata latched on accept)
//   resp_valid/resp_ready             response handshake (resp_rdata, resp_err held while waiting)
//   busy                              high whenever a request is in progress
module mips32_data_mem #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);
    localparam logic [3:0]  WAIT_W  = 4'(WAIT);

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      cnt;
    logic [3:0]      cnt_nxt;

    // request captured on accept; later changes on req_* have no effect
    logic            lat_we;
    logic            lat_err;
    logic [AW-1:0]   lat_idx;
    logic [31:0]     lat_wdata;

    logic            accept;
    logic            exec;
    logic            resp_done;

    logic [31:0]     mem [DEPTH];

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign busy       = (state != ST_IDLE);

    // The accept edge only captures the request. The WAIT state then holds
    // for WAIT programmed cycles plus the cycle in which the counter reads
    // zero, and the access commits on the edge that leaves WAIT for RESP.
    // With WAIT=0 this still gives one cycle in WAIT, so a response is never
    // produced on the same edge that accepted its request.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        exec      = 1'b0;
        resp_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    cnt_nxt   = WAIT_W;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    exec      = 1'b1;
                    state_nxt = ST_RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ST_RESP: begin
                // no accept in this cycle: IDLE (and req_ready) comes next edge
                if (resp_ready) begin
                    resp_done = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            lat_we     <= 1'b0;
            lat_err    <= 1'b0;
            lat_idx    <= '0;
            lat_wdata  <= 32'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                lat_we    <= req_we;
                lat_idx   <= req_addr[AW-1:0];
                lat_wdata <= req_wdata;
                // full 32-bit compare so large addresses never alias into range
                lat_err   <= (req_addr >= DEPTH_W);
            end
            if (exec) begin
                resp_err   <= lat_err;
                resp_rdata <= (lat_we || lat_err) ? 32'd0 : mem[lat_idx];
            end else if (resp_done) begin
                resp_rdata <= 32'd0;
                resp_err   <= 1'b0;
            end
        end
    end

    // Storage has no reset: contents survive reset. A reset on the commit
    // edge suppresses the write, so a pending store is never half-done.
    always_ff @(posedge clk) begin
        if (!reset && exec && lat_we && !lat_err) begin
            mem[lat_idx] <= lat_wdata;
        end
    end

endmodule

// File: tb/tb_mips32_data_mem.sv
module tb_mips32_data_mem;

    logic        clk;
    logic        reset;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    // instance with WAIT=2
    logic        req_valid, req_ready, resp_valid, resp_ready, resp_err, busy;
    logic [31:0] resp_rdata;
    // instance with WAIT=0
    logic        req_valid0, req_ready0, resp_valid0, resp_ready0, resp_err0, busy0;
    logic [31:0] resp_rdata0;

    int total = 0;
    int bad   = 0;

    mips32_data_mem #(.DEPTH(1024), .AW(10), .WAIT(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
    );

    mips32_data_mem #(.DEPTH(1024), .AW(10), .WAIT(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid0), .resp_ready(resp_ready0),
        .resp_rdata(resp_rdata0), .resp_err(resp_err0), .busy(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Full transaction on the WAIT=2 instance. Entered and left at #1 after a
    // posedge with the DUT idle. lat = edges after the accept edge until
    // resp_valid is seen.
    task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er, output int lat);
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        // scribble the inputs: they must not matter after acceptance
        req_addr  = 32'd1023;
        req_wdata = 32'hFFFF_FFFF;
        req_we    = ~we;
        lat = 0;
        while (!resp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = resp_rdata;
        er = resp_err;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          w;

        tbl[0]  = '{1'b1, 32'd5,          32'hDEAD_BEEF, 32'h0,         1'b0};
        tbl[1]  = '{1'b0, 32'd5,          32'h0,         32'hDEAD_BEEF, 1'b0};
        tbl[2]  = '{1'b1, 32'd0,          32'h1111_1111, 32'h0,         1'b0};
        tbl[3]  = '{1'b1, 32'd1023,       32'h2222_2222, 32'h0,         1'b0};
        tbl[4]  = '{1'b1, 32'd1024,       32'h0000_1234, 32'h0,         1'b1};
        tbl[5]  = '{1'b0, 32'd1024,       32'h0,         32'h0,         1'b1};
        tbl[6]  = '{1'b0, 32'd0,          32'h0,         32'h1111_1111, 1'b0};
        tbl[7]  = '{1'b0, 32'd1023,       32'h0,         32'h2222_2222, 1'b0};
        tbl[8]  = '{1'b0, 32'hFFFF_FFFF,  32'h0,         32'h0,         1'b1};
        tbl[9]  = '{1'b0, 32'd1023,       32'h0,         32'h2222_2222, 1'b0};
        tbl[10] = '{1'b1, 32'd7,          32'hCAFE_F00D, 32'h0,         1'b0};
        tbl[11] = '{1'b1, 32'd9,          32'h5A5A_5A5A, 32'h0,         1'b0};

        reset = 1'b1;
        req_valid = 1'b0; req_valid0 = 1'b0;
        resp_ready = 1'b0; resp_ready0 = 1'b0;
        req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready",  {31'd0, req_ready},  32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata,          32'd0);
        chk("rst_resp_err",   {31'd0, resp_err},   32'd0);
        chk("rst_busy",       {31'd0, busy},       32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // table-driven store/load/boundary sequence
        for (int i = 0; i < 12; i++) begin
            txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, rd, er, lat);
            chk($sformatf("v%0d_rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("v%0d_err", i), {31'd0, er}, {31'd0, tbl[i].exp_err});
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
        end

        // response backpressure on LW 7
        req_we = 1'b0; req_addr = 32'd7; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        w = 0;
        while (!resp_valid && w < 40) begin @(posedge clk); #1; w++; end
        chk("bp_resp_valid_rise", {31'd0, resp_valid}, 32'd1);
        // competing store to the same word while the response is stalled
        req_we = 1'b1; req_addr = 32'd7; req_wdata = 32'h0; req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp%0d_resp_valid", c), {31'd0, resp_valid}, 32'd1);
            chk($sformatf("bp%0d_rdata", c), resp_rdata, 32'hCAFE_F00D);
            chk($sformatf("bp%0d_req_ready", c), {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("bp_after_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("bp_after_req_ready",  {31'd0, req_ready},  32'd1);
        chk("bp_after_rdata",      resp_rdata,          32'd0);
        chk("bp_after_busy",       {31'd0, busy},       32'd0);
        req_valid = 1'b0;
        txn(1'b0, 32'd7, 32'd0, rd, er, lat);
        chk("bp_reload_rdata", rd, 32'hCAFE_F00D);

        // reset while in WAIT drops the store to addr 9
        req_we = 1'b1; req_addr = 32'd9; req_wdata = 32'hA5A5_A5A5; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rw_busy_in_wait", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rw_req_ready",  {31'd0, req_ready},  32'd1);
        chk("rw_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rw_resp_rdata", resp_rdata,          32'd0);
        chk("rw_resp_err",   {31'd0, resp_err},   32'd0);
        chk("rw_busy",       {31'd0, busy},       32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rw_no_late_resp", {31'd0, resp_valid}, 32'd0);
        txn(1'b0, 32'd9, 32'd0, rd, er, lat);
        chk("rw_prior_value", rd, 32'h5A5A_5A5A);

        // reset while in RESP: store already committed, response dropped
        req_we = 1'b1; req_addr = 32'd9; req_wdata = 32'h7777_7777; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        w = 0;
        while (!resp_valid && w < 40) begin @(posedge clk); #1; w++; end
        chk("rr_resp_valid", {31'd0, resp_valid}, 32'd1);
        reset = 1'b1; resp_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; resp_ready = 1'b0;
        chk("rr_dropped", {31'd0, resp_valid}, 32'd0);
        chk("rr_busy",    {31'd0, busy},       32'd0);
        txn(1'b0, 32'd9, 32'd0, rd, er, lat);
        chk("rr_committed", rd, 32'h7777_7777);

        // WAIT=0 instance: requests held valid, resp_ready held high
        req_we = 1'b1; req_addr = 32'd3; req_wdata = 32'h0000_0033;
        req_valid0 = 1'b1; resp_ready0 = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            chk($sformatf("w0_c%0d_req_ready", c), {31'd0, req_ready0},
                (c % 3 == 1) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
            chk($sformatf("w0_c%0d_resp_valid", c), {31'd0, resp_valid0},
                (c % 3 == 2) ? 32'd1 : 32'd0);
        end
        req_we = 1'b0; req_addr = 32'd3;
        @(posedge clk); #1;
        req_valid0 = 1'b0;
        @(posedge clk); #1;
        chk("w0_load_valid", {31'd0, resp_valid0}, 32'd1);
        chk("w0_load_rdata", resp_rdata0,          32'h0000_0033);
        chk("w0_load_err",   {31'd0, resp_err0},   32'd0);
        @(posedge clk); #1;
        resp_ready0 = 1'b0;
        chk("w0_idle_after", {31'd0, busy0}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
